// File: rtl/id_ex_pipe_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_stage_if
//   Bundle of every non-clock/reset signal of the ID/EX pipeline stage.
//   slave  : the stage's view (decode-side inputs in, execute-side outputs out)
//   master : the surrounding core's view (drives decode payload, consumes
//            execute payload, supplies later-stage rd / regwrite)
// Signals
//   in_valid/in_ready       decode-side handshake
//   in_ir/in_words/in_ctrl  decode payload (word k at [k*XLEN +: XLEN])
//   flush                   kill held and incoming entries
//   out_valid/out_ready     execute-side handshake
//   out_ir/out_words/out_ctrl, out_rs1/out_rs2/out_rd   registered payload
//   hazard_stall            load-use hazard, fetch/decode must hold
//   exmem_rd/exmem_regwrite, memwb_rd/memwb_regwrite  later-stage writers
//   fwd_sel_a/fwd_sel_b     ALU operand forwarding selects
// ---------------------------------------------------------------------------
interface id_ex_pipe_stage_if #(
    parameter int XLEN      = 32,
    parameter int NUM_WORDS = 9,
    parameter int CTRL_W    = 10
);
    logic                      in_valid;
    logic                      in_ready;
    logic [XLEN-1:0]           in_ir;
    logic [NUM_WORDS*XLEN-1:0] in_words;
    logic [CTRL_W-1:0]         in_ctrl;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_ir;
    logic [NUM_WORDS*XLEN-1:0] out_words;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [4:0]                out_rs1;
    logic [4:0]                out_rs2;
    logic [4:0]                out_rd;
    logic                      hazard_stall;
    logic [4:0]                exmem_rd;
    logic [4:0]                memwb_rd;
    logic                      exmem_regwrite;
    logic                      memwb_regwrite;
    logic [1:0]                fwd_sel_a;
    logic [1:0]                fwd_sel_b;

    modport slave (
        input  in_valid, in_ir, in_words, in_ctrl, flush, out_ready,
               exmem_rd, memwb_rd, exmem_regwrite, memwb_regwrite,
        output in_ready, out_valid, out_ir, out_words, out_ctrl,
               out_rs1, out_rs2, out_rd, hazard_stall, fwd_sel_a, fwd_sel_b
    );

    modport master (
        output in_valid, in_ir, in_words, in_ctrl, flush, out_ready,
               exmem_rd, memwb_rd, exmem_regwrite, memwb_regwrite,
        input  in_ready, out_valid, out_ir, out_words, out_ctrl,
               out_rs1, out_rs2, out_rd, hazard_stall, fwd_sel_a, fwd_sel_b
    );
endinterface

// File: rtl/id_ex_pipe_stage.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_stage
//   ID/EX pipeline register for the pipelined OTTER core: single-edge,
//   valid/ready, two-entry (main + skid) FIFO with flush (bubble insert),
//   load-use hazard detection and optional forwarding-select generation.
// Ports
//   REG_CLOCK  clock, all state on rising edge
//   REG_RESET  synchronous active-high reset
//   bus        id_ex_pipe_stage_if.slave (handshakes, payloads, hazard,
//              forwarding inputs/outputs)
// Configuration
//   ID_EX_FWD_UNIT_EN  when defined, fwd_sel_a/b are generated from the
//                      registered rs1/rs2 against EX/MEM and MEM/WB writers;
//                      otherwise both selects are constant 00.
// ---------------------------------------------------------------------------
module id_ex_pipe_stage #(
    parameter int XLEN        = 32,
    parameter int NUM_WORDS   = 9,
    parameter int CTRL_W      = 10,
    parameter int MEMREAD_BIT = 2
) (
    input  logic               REG_CLOCK,
    input  logic               REG_RESET,
    id_ex_pipe_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [XLEN-1:0]           r_main_ir;
    logic [NUM_WORDS*XLEN-1:0] r_main_words;
    logic [CTRL_W-1:0]         r_main_ctrl;
    logic [XLEN-1:0]           r_skid_ir;
    logic [NUM_WORDS*XLEN-1:0] r_skid_words;
    logic [CTRL_W-1:0]         r_skid_ctrl;

    logic                      w_out_valid;
    logic                      w_in_ready;
    logic                      w_hazard;
    logic                      w_accept;
    logic                      w_drain;
    logic                      w_load_main;
    logic                      w_load_skid;
    logic                      w_main_from_skid;
    logic [4:0]                w_main_rd;

    assign w_main_rd = r_main_ir[11:7];

    // Load-use: the instruction held in main is a load whose destination is
    // read by the incoming instruction. Uses r_state directly (not
    // w_out_valid) so the ready path has no combinational self-dependency.
    assign w_hazard = !bus.flush
                   && (r_state != ST_EMPTY)
                   && r_main_ctrl[MEMREAD_BIT]
                   && (w_main_rd != 5'd0)
                   && bus.in_valid
                   && ((w_main_rd == bus.in_ir[19:15]) || (w_main_rd == bus.in_ir[24:20]));

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_drain  = w_out_valid && bus.out_ready;

    // FSM: state register
    always_ff @(posedge REG_CLOCK) begin
        if (REG_RESET) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state (flush wins over every handshake)
    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
                ST_FULL: begin
                    if (w_accept && !w_drain)      w_state_next = ST_SKID;
                    else if (!w_accept && w_drain) w_state_next = ST_EMPTY;
                end
                ST_SKID:  if (w_drain) w_state_next = ST_FULL;
                default:  w_state_next = ST_EMPTY;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        w_out_valid = (r_state != ST_EMPTY);
        w_in_ready  = (r_state != ST_SKID) && !w_hazard && !REG_RESET;
    end

    // Main is loaded from the input when it is (or is about to be) free and
    // no older entry waits in skid; from skid when skid holds the next entry.
    assign w_load_skid      = (r_state == ST_FULL) && w_accept && !w_drain;
    assign w_load_main      = ((r_state == ST_EMPTY) && w_accept)
                           || ((r_state == ST_FULL) && w_accept && w_drain)
                           || ((r_state == ST_SKID) && w_drain);
    assign w_main_from_skid = (r_state == ST_SKID);

    always_ff @(posedge REG_CLOCK) begin
        if (REG_RESET) begin
            r_main_ir    <= '0;
            r_main_words <= '0;
            r_main_ctrl  <= '0;
            r_skid_ir    <= '0;
            r_skid_words <= '0;
            r_skid_ctrl  <= '0;
        end else if (bus.flush) begin
            // Bubble: no regWrite/memWrite can escape a killed entry.
            r_main_ctrl <= '0;
        end else begin
            if (w_load_skid) begin
                r_skid_ir    <= bus.in_ir;
                r_skid_words <= bus.in_words;
                r_skid_ctrl  <= bus.in_ctrl;
            end
            if (w_load_main) begin
                r_main_ir    <= w_main_from_skid ? r_skid_ir    : bus.in_ir;
                r_main_words <= w_main_from_skid ? r_skid_words : bus.in_words;
                r_main_ctrl  <= w_main_from_skid ? r_skid_ctrl  : bus.in_ctrl;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_ir       = r_main_ir;
    assign bus.out_words    = r_main_words;
    assign bus.out_ctrl     = r_main_ctrl;
    assign bus.out_rs1      = r_main_ir[19:15];
    assign bus.out_rs2      = r_main_ir[24:20];
    assign bus.out_rd       = w_main_rd;
    assign bus.hazard_stall = w_hazard;

`ifdef ID_EX_FWD_UNIT_EN
    logic [1:0][4:0] w_fwd_rs;
    logic [1:0][1:0] w_fwd_sel;

    assign w_fwd_rs[0] = r_main_ir[19:15];
    assign w_fwd_rs[1] = r_main_ir[24:20];

    // EX/MEM is the younger producer, so it takes priority over MEM/WB.
    function automatic logic [1:0] fwd_select(input logic [4:0] rs, input logic vld,
                                              input logic ex_we, input logic [4:0] ex_rd,
                                              input logic wb_we, input logic [4:0] wb_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (vld) begin
            if (ex_we && (ex_rd != 5'd0) && (ex_rd == rs))      sel = 2'b01;
            else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) sel = 2'b10;
        end
        return sel;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign w_fwd_sel[gi] = fwd_select(w_fwd_rs[gi], w_out_valid,
                                          bus.exmem_regwrite, bus.exmem_rd,
                                          bus.memwb_regwrite, bus.memwb_rd);
    end

    assign bus.fwd_sel_a = w_fwd_sel[0];
    assign bus.fwd_sel_b = w_fwd_sel[1];
`else
    assign bus.fwd_sel_a = 2'b00;
    assign bus.fwd_sel_b = 2'b00;
`endif

endmodule
